// File: rtl/alu_pkg.sv
// Shared widths, FSM encoding and port index type for the two-port ALU arbiter.
package alu_pkg;

   localparam int DW  = 32;
   localparam int OPW = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef logic port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the preferred port wins when it requests, otherwise the other port.
// Purely combinational, one-hot grant plus its index; no grant when neither port requests.
module rr_arb2
   import alu_pkg::*;
(
   input  logic [1:0] i_req,
   input  port_t      i_rr_ptr,
   output logic [1:0] o_gnt,
   output port_t      o_gnt_id
);

   always_comb begin
      o_gnt    = 2'b00;
      o_gnt_id = i_rr_ptr;
      if (i_req[i_rr_ptr]) begin
         o_gnt[i_rr_ptr] = 1'b1;
         o_gnt_id        = i_rr_ptr;
      end else if (i_req[~i_rr_ptr]) begin
         o_gnt[~i_rr_ptr] = 1'b1;
         o_gnt_id         = ~i_rr_ptr;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; one command in flight, round-robin grant.
// Accept edge N, ALU evaluated in EXEC, registered result valid after edge N+1, held until rsp_ready.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [2*DW-1:0]      req_a,
   input  logic [2*DW-1:0]      req_b,
   input  logic [2*OPW-1:0]     req_op,
   output logic [1:0]           rsp_valid,
   output logic [DW-1:0]        rsp_out,
   input  logic [1:0]           rsp_ready,
   output logic [DW-1:0]        alu_a,
   output logic [DW-1:0]        alu_b,
   output logic [OPW-1:0]       alu_op,
   input  logic [DW-1:0]        alu_out
);

   state_t           r_state;
   state_t           w_next;
   port_t            r_ptr;
   port_t            r_gnt_id;
   port_t            w_gnt_id;
   logic [1:0]       w_gnt;
   logic             w_accept;
   logic             w_rsp_hs;
   logic [DW-1:0]    r_a;
   logic [DW-1:0]    r_b;
   logic [OPW-1:0]   r_op;
   logic [DW-1:0]    r_rsp;
   logic [1:0]       r_rsp_vld;
   logic [DW-1:0]    w_sel_a;
   logic [DW-1:0]    w_sel_b;
   logic [OPW-1:0]   w_sel_op;

   rr_arb2 u_arb (
      .i_req    (req_valid),
      .i_rr_ptr (r_ptr),
      .o_gnt    (w_gnt),
      .o_gnt_id (w_gnt_id)
   );

   assign w_sel_a  = w_gnt_id ? req_a[DW +: DW]   : req_a[0 +: DW];
   assign w_sel_b  = w_gnt_id ? req_b[DW +: DW]   : req_b[0 +: DW];
   assign w_sel_op = w_gnt_id ? req_op[OPW +: OPW] : req_op[0 +: OPW];

   // req_ready is forced low during reset so nothing is accepted on a reset edge.
   always_comb begin
      w_next    = r_state;
      req_ready = 2'b00;
      w_accept  = 1'b0;
      w_rsp_hs  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!rst && (|w_gnt)) begin
               req_ready = w_gnt;
               w_accept  = 1'b1;
               w_next    = ST_EXEC;
            end
         end
         ST_EXEC: w_next = ST_RESP;
         ST_RESP: begin
            if (rsp_ready[r_gnt_id]) begin
               w_rsp_hs = 1'b1;
               w_next   = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= 1'b0;
         r_gnt_id  <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= '0;
         r_rsp     <= '0;
         r_rsp_vld <= 2'b00;
      end else begin
         if (w_accept) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_op     <= w_sel_op;
            r_gnt_id <= w_gnt_id;
            r_ptr    <= ~w_gnt_id;
         end
         if (r_state == ST_EXEC) begin
            r_rsp     <= alu_out;
            r_rsp_vld <= r_gnt_id ? 2'b10 : 2'b01;
         end
         if (w_rsp_hs) r_rsp_vld <= 2'b00;
      end
   end

   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign alu_op    = r_op;
   assign rsp_out   = r_rsp;
   assign rsp_valid = r_rsp_vld;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: randomized commands checked against a round-robin/arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_arbiter;
   import alu_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
   logic [2*DW-1:0]   req_a, req_b;
   logic [2*OPW-1:0]  req_op;
   logic [DW-1:0]     rsp_out, alu_a, alu_b, alu_out;
   logic [OPW-1:0]    alu_op;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int m_pref   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OPW-1:0] op);
      case (op)
         5'h00:   return a + b;
         5'h01:   return a - b;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_out = ref_alu(alu_a, alu_b, alu_op);

   alu_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_ready(rsp_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
   );

   // Reference model: preferred port wins if valid, else the other; preference flips after a grant.
   function automatic int model_pick(input logic [1:0] vld);
      int p;
      p = m_pref;
      if (!vld[p]) p = 1 - p;
      return p;
   endfunction

   function automatic logic [DW-1:0] model_rsp(input int p);
      return ref_alu(req_a[p*DW +: DW], req_b[p*DW +: DW], req_op[p*OPW +: OPW]);
   endfunction

   task automatic set_cmd(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [OPW-1:0] op);
      req_a[p*DW +: DW]    = a;
      req_b[p*DW +: DW]    = b;
      req_op[p*OPW +: OPW] = op;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; m_pref = 0;
      #1;
   endtask

   // Observations of one transaction, filled by transact and judged by each test.
   int              ob_port, ob_lat, ob_cyc;
   logic [1:0]      ob_gnt, ob_exec_rdy, ob_rsp_vld, ob_after_vld, ob_after_rdy;
   logic [DW-1:0]   ob_rsp, ob_alu_a;
   bit              ob_stable, ob_timeout;

   task automatic transact(input logic [1:0] vld, input int bp);
      int n;
      ob_timeout = 0; ob_stable = 1; ob_port = -1; ob_lat = -1;
      req_valid  = vld;
      rsp_ready  = (bp == 0) ? 2'b11 : 2'b00;
      #1;
      n = 0;
      while ((req_ready & req_valid) == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
      if ((req_ready & req_valid) == 2'b00) begin ob_timeout = 1; req_valid = 2'b00; return; end
      ob_gnt  = req_ready;
      ob_port = req_ready[1] ? 1 : 0;
      ob_cyc  = cyc;
      if (bp > 0) rsp_ready[1-ob_port] = 1'b1;
      @(posedge clk); #1;
      req_valid[ob_port] = 1'b0;
      @(negedge clk); #1;
      ob_exec_rdy = req_ready;
      ob_alu_a    = alu_a;
      n = 0;
      while (rsp_valid == 2'b00 && n < 10) begin @(negedge clk); #1; n++; end
      ob_lat = n; ob_rsp = rsp_out; ob_rsp_vld = rsp_valid;
      if (rsp_valid == 2'b00) begin ob_timeout = 1; return; end
      for (int i = 0; i < bp; i++) begin
         if (rsp_out !== ob_rsp || rsp_valid !== ob_rsp_vld || req_ready !== 2'b00) ob_stable = 0;
         @(negedge clk); #1;
      end
      rsp_ready[ob_port] = 1'b1;
      #1;
      if (req_ready !== 2'b00) ob_stable = 0;
      @(negedge clk); #1;
      ob_after_vld = rsp_valid;
      ob_after_rdy = req_ready;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
      set_cmd(0, 32'd5, 32'd2, 5'h00);
      set_cmd(1, 32'd9, 32'd4, 5'h00);
      @(posedge clk); #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
      n_checks++; if (rsp_out !== '0) begin n_fail++; $display("FAIL reset_rsp_out: got %h want 0", rsp_out); end
      n_checks++; if ({alu_a, alu_b, alu_op} !== '0) begin n_fail++; $display("FAIL reset_alu: got a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op); end
      @(posedge clk); #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready_hold: got %b want 00", req_ready); end
      @(negedge clk);
      rst = 1'b0; m_pref = 0;
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_release_p0_wins: got %b want 01", req_ready); end
      req_valid = 2'b00;
      #1;
   endtask

   task automatic test_single_port();
      int exp;
      set_cmd(0, 32'd5, 32'd2, 5'h00);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) set_cmd(0, $urandom, $urandom, 5'($urandom_range(0, 1)));
         exp = model_pick(2'b01);
         transact(2'b01, 0);
         n_checks++; if (ob_timeout) begin n_fail++; $display("FAIL single_timeout: got timeout want response"); end
         n_checks++; if (ob_gnt !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", ob_gnt); end
         n_checks++; if (ob_exec_rdy !== 2'b00) begin n_fail++; $display("FAIL single_exec_ready: got %b want 00", ob_exec_rdy); end
         n_checks++; if (ob_alu_a !== req_a[0 +: DW]) begin n_fail++; $display("FAIL single_alu_a: got %h want %h", ob_alu_a, req_a[0 +: DW]); end
         n_checks++; if (ob_lat !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1 edge after accept edge", ob_lat); end
         n_checks++; if (ob_rsp_vld !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 01", ob_rsp_vld); end
         n_checks++; if (ob_rsp !== model_rsp(exp)) begin n_fail++; $display("FAIL single_rsp_out: got %h want %h", ob_rsp, model_rsp(exp)); end
         n_checks++; if (ob_after_vld !== 2'b00) begin n_fail++; $display("FAIL single_rsp_clear: got %b want 00", ob_after_vld); end
         m_pref = 1 - exp;
      end
      n_checks++; if (model_rsp(0) === '0 && ob_rsp !== '0) begin n_fail++; $display("FAIL single_zero: got %h want 0", ob_rsp); end
   endtask

   task automatic test_both_ports();
      int exp;
      do_reset();
      set_cmd(0, 32'd5, 32'd2, 5'h01);
      set_cmd(1, 32'd9, 32'd4, 5'h00);
      for (int k = 0; k < 4; k++) begin
         exp = model_pick(2'b11);
         transact(2'b11, 0);
         n_checks++; if (ob_port !== exp) begin n_fail++; $display("FAIL both_order[%0d]: got port %0d want %0d", k, ob_port, exp); end
         n_checks++; if (ob_rsp !== model_rsp(exp)) begin n_fail++; $display("FAIL both_rsp[%0d]: got %h want %h", k, ob_rsp, model_rsp(exp)); end
         n_checks++; if (ob_rsp_vld !== (exp == 1 ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL both_rsp_valid[%0d]: got %b want port %0d", k, ob_rsp_vld, exp); end
         m_pref = 1 - exp;
      end
   endtask

   task automatic test_backpressure();
      int exp;
      do_reset();
      set_cmd(0, $urandom, $urandom, 5'h00);
      set_cmd(1, $urandom, $urandom, 5'h01);
      exp = model_pick(2'b11);
      transact(2'b11, 5);
      n_checks++; if (ob_port !== exp) begin n_fail++; $display("FAIL bp_grant: got %0d want %0d", ob_port, exp); end
      n_checks++; if (!ob_stable) begin n_fail++; $display("FAIL bp_stable: got unstable rsp or nonzero req_ready want held"); end
      n_checks++; if (ob_rsp !== model_rsp(exp)) begin n_fail++; $display("FAIL bp_rsp: got %h want %h", ob_rsp, model_rsp(exp)); end
      n_checks++; if (ob_after_vld !== 2'b00) begin n_fail++; $display("FAIL bp_release: got %b want 00", ob_after_vld); end
      n_checks++; if (ob_after_rdy !== 2'b10) begin n_fail++; $display("FAIL bp_idle_ready: got %b want 10", ob_after_rdy); end
      m_pref = 1 - exp;
      exp = model_pick(2'b10);
      transact(2'b10, 0);
      n_checks++; if (ob_rsp !== model_rsp(exp) || ob_port !== exp) begin n_fail++; $display("FAIL bp_drain: got port %0d rsp %h want port %0d rsp %h", ob_port, ob_rsp, exp, model_rsp(exp)); end
      m_pref = 1 - exp;
   endtask

   task automatic test_reset_in_exec();
      int  n;
      bit  seen;
      for (int p = 1; p >= 0; p--) begin
         set_cmd(p, $urandom, $urandom, 5'h00);
         req_valid = (p == 1) ? 2'b10 : 2'b01;
         rsp_ready = 2'b11;
         #1;
         n = 0;
         while ((req_ready & req_valid) == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
         n_checks++; if ((req_ready & req_valid) == 2'b00) begin n_fail++; $display("FAIL rexec_accept[%0d]: got no accept want accept", p); end
         @(posedge clk); #1;
         req_valid = 2'b00;
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0; m_pref = 0;
         seen = 0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (rsp_valid !== 2'b00) seen = 1;
         end
         n_checks++; if (seen) begin n_fail++; $display("FAIL rexec_no_rsp[%0d]: got rsp_valid set want none", p); end
         n_checks++; if (alu_a !== '0) begin n_fail++; $display("FAIL rexec_alu_clear[%0d]: got %h want 0", p, alu_a); end
         req_valid = 2'b11;
         #1;
         n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rexec_ptr[%0d]: got %b want 01", p, req_ready); end
         req_valid = 2'b00;
         #1;
      end
   endtask

   task automatic test_back_to_back();
      int exp, prev;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         set_cmd(1, $urandom, $urandom, 5'($urandom_range(0, 1)));
         exp = model_pick(2'b10);
         transact(2'b10, 0);
         n_checks++; if (ob_port !== exp) begin n_fail++; $display("FAIL b2b_port[%0d]: got %0d want %0d", k, ob_port, exp); end
         n_checks++; if (ob_rsp !== model_rsp(exp)) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %h want %h", k, ob_rsp, model_rsp(exp)); end
         n_checks++; if (ob_rsp_vld !== 2'b10) begin n_fail++; $display("FAIL b2b_rsp_valid[%0d]: got %b want 10", k, ob_rsp_vld); end
         if (k > 0) begin
            n_checks++; if (ob_cyc - prev !== 3) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", k, ob_cyc - prev); end
         end
         prev = ob_cyc;
         m_pref = 1 - exp;
      end
   endtask

   task automatic test_random();
      int exp, bp;
      logic [1:0] vld;
      for (int k = 0; k < 24; k++) begin
         vld = 2'($urandom_range(1, 3));
         bp  = $urandom_range(0, 2);
         set_cmd(0, $urandom, $urandom, 5'($urandom_range(0, 2)));
         set_cmd(1, $urandom, $urandom, 5'($urandom_range(0, 2)));
         exp = model_pick(vld);
         transact(vld, bp);
         n_checks++; if (ob_port !== exp) begin n_fail++; $display("FAIL rand_port[%0d]: got %0d want %0d", k, ob_port, exp); end
         n_checks++; if (ob_rsp !== model_rsp(exp)) begin n_fail++; $display("FAIL rand_rsp[%0d]: got %h want %h", k, ob_rsp, model_rsp(exp)); end
         n_checks++; if (!ob_stable || ob_after_vld !== 2'b00) begin n_fail++; $display("FAIL rand_handshake[%0d]: got stable=%0d after=%b want 1/00", k, ob_stable, ob_after_vld); end
         m_pref = 1 - exp;
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      req_a = '0; req_b = '0; req_op = '0;
      test_reset();
      test_single_port();
      test_both_ports();
      test_backpressure();
      test_reset_in_exec();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion want finish before 400us");
      $fatal(1, "watchdog");
   end

endmodule
